t2p_event_rx: RTL and testbench
===============================

// Module: t2p_event_rx
// PURPOSE
//  Destination-domain receiver for the pulse-to-level (toggle) CDC path.
//  - Consumes the toggling level produced by the source-side pulse-to-level stage (asynchronous to clk2).
//  - Synchronises it and regenerates one single-cycle pulse per toggle.
//  - Queues events in a saturating pending counter, drained by a valid/ready consumer.
//  - Returns the synchronised level to the source as an acknowledge.
// PARAMETERS
//  SYNC_STAGES  2  flops in the synchroniser chain; legal range 2..4
//  CNT_W        4  pending-event counter width; max pending = 2**CNT_W-1
// PORTS
//  clk2       in   1      destination clock; all logic is on its rising edge
//  reset      in   1      asynchronous, active-low reset
//  toggle_in  in   1      toggling level from the source domain; asynchronous to clk2
//  evt_pulse  out  1      one-cycle pulse per detected toggle, either edge
//  evt_valid  out  1      high while evt_count != 0
//  evt_ready  in   1      consumer accepts one event on an edge where evt_valid && evt_ready
//  evt_count  out  CNT_W  pending events, registered
//  ovf        out  1      sticky; set when an event is lost to saturation
//  ovf_clr    in   1      synchronous clear of ovf
//  ack_lvl    out  1      synchronised copy of toggle_in (prev flop), returned to source
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - Sync chain, prev, evt_pulse, evt_count, ovf, ack_lvl and warm counter all go to 0.
//  Synchroniser:
//   - s[0] <= toggle_in; s[i] <= s[i-1].
//   - prev <= s[S-1].
//   - edge = s[S-1] ^ prev (combinational).
//  Latency:
//   - A toggle_in change sampled at edge k gives evt_pulse=1 from edge k+S to edge k+S+1.
//   - evt_count increments at edge k+S, where S = SYNC_STAGES.
//  Warm-up:
//   - A warm counter runs 0..S after reset deassertion.
//   - Until it reaches S, edge is masked: no pulse and no count. prev still tracks s[S-1].
//   - A toggle_in held at 1 through reset therefore produces no spurious event.
//  Counter update, per edge. pop = evt_valid & evt_ready:
//   - edge & !pop:
//     - below max: count+1.
//     - at max: hold, ovf <= 1.
//   - !edge & pop: count-1.
//   - edge & pop: count unchanged, ovf unchanged. Applies even at max.
//   - Neither: hold.
//  Underflow:
//   - evt_valid=0 means no pop is possible, so count never goes below 0.
//   - evt_ready while empty is ignored.
//  ovf:
//   - ovf_clr=1 clears ovf.
//   - When ovf_clr=1 and a saturation event occur on the same edge, set wins: ovf=1.
//  Toggle spacing:
//   - Back-to-back toggles closer than one clk2 period may merge; this is a source-side rule.
//   - The source must wait for ack_lvl == its toggle level before toggling again.
//  ack_lvl = prev, i.e. the level already counted.
//  Reset mid-operation:
//   - Pending events and ovf are discarded.
//   - Warm-up restarts.
// STRUCTURE
//  Shared package cdc_pkg:
//   - CDC_SYNC_STAGES_DEF = 2.
//   - CDC_EVT_CNT_W_DEF = 4.
//   - typedef of the counter update enum {HOLD, INC, DEC, SAT}.
//  Sub-module cdc_sync_bit (SYNC_STAGES):
//   - Generic 1-bit synchroniser chain with async active-low reset.
//   - Reused by other CDC receivers.
//   - Synthesis attribute ASYNC_REG on its flops.
//  Top:
//   - Edge detect.
//   - Warm-up counter.
//   - Saturating up/down counter.
//   - ovf flag.
// TESTING
//  1. Single toggle: reset released, then toggle_in 0->1 at edge 5 with evt_ready=0
//     -> evt_pulse high for exactly edge 7..8; evt_count=1; evt_valid=1; ack_lvl=1.
//  2. Both edges: toggle 0->1, then 1->0 six cycles later, evt_ready=0
//     -> two pulses; evt_count=2. Then evt_ready=1 for 2 cycles -> count 0; evt_valid=0.
//  3. Saturation (CNT_W=2): 4 toggles spaced 6 cycles, no pops
//     -> count stops at 3; ovf=1 after 4th. ovf_clr pulse -> ovf=0, count stays 3.
//  4. Simultaneous: count=2, evt_ready=1 on the edge a pulse arrives -> count stays 2.
//     At max=3 same -> stays 3, ovf unchanged.
//  5. Warm-up: toggle_in=1 held through reset and release -> no evt_pulse; count 0; ack_lvl=1 after S+1 edges.
//  6. Reset mid-operation: count=3, ovf=1, assert reset between edges
//     -> all outputs 0 immediately, no clock needed. Toggle after release counts 1.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing receivers.
package cdc_pkg;

   localparam int CDC_SYNC_STAGES_DEF = 2;
   localparam int CDC_EVT_CNT_W_DEF   = 4;

   typedef enum logic [1:0] {
      HOLD,
      INC,
      DEC,
      SAT
   } cnt_upd_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Generic single-bit synchroniser chain; q is d delayed by SYNC_STAGES flops.
module cdc_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] s;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s <= '0;
      end else begin
         s <= {s[SYNC_STAGES-2:0], d};
      end
   end

   assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/t2p_event_rx.sv
// Toggle-CDC receiver: regenerates one pulse per toggle, queues events in a
// saturating counter drained by a valid/ready consumer, and returns an ack level.
module t2p_event_rx
   import cdc_pkg::*;
#(
   parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF,
   parameter int CNT_W       = CDC_EVT_CNT_W_DEF
) (
   input  logic             clk2,
   input  logic             reset,
   input  logic             toggle_in,
   output logic             evt_pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] evt_count,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic             ack_lvl
);

   localparam int                 WARM_W   = $clog2(SYNC_STAGES + 1);
   localparam logic [WARM_W-1:0]  WARM_END = WARM_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   logic              sync_q;
   logic              prev;
   logic              armed;
   logic              evt_edge;
   logic              pop;
   logic [WARM_W-1:0] warm;
   cnt_upd_e          upd;

   cdc_sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk2),
      .rst_n(reset),
      .d    (toggle_in),
      .q    (sync_q)
   );

   // armed rises one edge after warm reaches SYNC_STAGES, so the edge seen when a
   // level held through reset first reaches prev is masked.
   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         prev      <= 1'b0;
         warm      <= '0;
         armed     <= 1'b0;
         evt_pulse <= 1'b0;
      end else begin
         prev      <= sync_q;
         if (warm != WARM_END) warm <= warm + WARM_W'(1);
         armed     <= (warm == WARM_END);
         evt_pulse <= evt_edge;
      end
   end

   assign evt_edge  = (sync_q ^ prev) & armed;
   assign evt_valid = (evt_count != '0);
   assign pop       = evt_valid & evt_ready;
   assign ack_lvl   = prev;

   // NOTE: upd gets its default before any branch so no latch is inferred.
   always_comb begin
      upd = HOLD;
      if (evt_edge && !pop) begin
         upd = (evt_count == CNT_MAX) ? SAT : INC;
      end else if (!evt_edge && pop) begin
         upd = DEC;
      end
   end

   always_ff @(posedge clk2 or negedge reset) begin
      if (!reset) begin
         evt_count <= '0;
         ovf       <= 1'b0;
      end else begin
         case (upd)
            INC:     evt_count <= evt_count + CNT_W'(1);
            DEC:     evt_count <= evt_count - CNT_W'(1);
            default: evt_count <= evt_count;
         endcase
         // A saturation on the same edge as a clear leaves the flag set.
         if (upd == SAT) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_t2p_event_rx.sv
// Self-checking bench for t2p_event_rx: directed table, corner sequences and a
// randomized run against a history-based reference model.
module tb_t2p_event_rx;

   localparam int S   = 2;
   localparam int CW  = 2;
   localparam int MAX = (1 << CW) - 1;

   logic          clk2 = 1'b0;
   logic          reset;
   logic          toggle_in;
   logic          evt_pulse;
   logic          evt_valid;
   logic          evt_ready;
   logic [CW-1:0] evt_count;
   logic          ovf;
   logic          ovf_clr;
   logic          ack_lvl;

   int checks   = 0;
   int failures = 0;

   // Reference model: every toggle_in sample since reset release, plus the queue state.
   bit hist[$];
   int m_n;
   int m_count;
   bit m_ovf;
   bit m_pulse;

   typedef struct {
      bit tog;
      bit rdy;
      bit clr;
      bit e_pulse;
      int e_cnt;
      bit e_ovf;
      bit e_ack;
   } vec_t;

   vec_t tbl[17];

   t2p_event_rx #(
      .SYNC_STAGES(S),
      .CNT_W      (CW)
   ) dut (
      .clk2     (clk2),
      .reset    (reset),
      .toggle_in(toggle_in),
      .evt_pulse(evt_pulse),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_count(evt_count),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr),
      .ack_lvl  (ack_lvl)
   );

   always #5 clk2 = ~clk2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit samp(input int k);
      if (k < 1 || k > hist.size()) return 1'b0;
      return hist[k-1];
   endfunction

   task automatic model_clear();
      hist.delete();
      m_n     = 0;
      m_count = 0;
      m_ovf   = 1'b0;
      m_pulse = 1'b0;
   endtask

   // An event registers at edge n when the samples taken S and S+1 edges earlier
   // differ, except during the first S+1 edges after release.
   task automatic model_edge();
      bit ev, pop, sat;
      if (!reset) begin
         model_clear();
         return;
      end
      hist.push_back(toggle_in);
      m_n++;
      ev  = (m_n > S + 1) && (samp(m_n - S) != samp(m_n - S - 1));
      pop = (m_count > 0) && evt_ready;
      sat = ev && !pop && (m_count == MAX);
      if (ev && !pop && !sat) m_count++;
      else if (!ev && pop)    m_count--;
      m_ovf   = sat ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      m_pulse = ev;
   endtask

   task automatic compare_model(input string tag);
      check({tag, ".pulse"}, 32'(evt_pulse), 32'(m_pulse));
      check({tag, ".count"}, 32'(evt_count), 32'(m_count));
      check({tag, ".valid"}, 32'(evt_valid), 32'(m_count != 0));
      check({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
      check({tag, ".ack"},   32'(ack_lvl),   32'(samp(m_n - S)));
   endtask

   task automatic tick();
      @(posedge clk2);
      model_edge();
      @(negedge clk2);
      compare_model("model");
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called just after a falling edge; asserts reset between clock edges.
   task automatic assert_reset();
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      compare_model("async_rst");
   endtask

   function automatic vec_t mk(input bit tog, input bit rdy, input bit clr, input bit pulse,
                               input int cnt, input bit o, input bit ack);
      vec_t v;
      v.tog = tog; v.rdy = rdy; v.clr = clr;
      v.e_pulse = pulse; v.e_cnt = cnt; v.e_ovf = o; v.e_ack = ack;
      return v;
   endfunction

   initial begin
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(1, 0, 0, 1, 1, 0, 1);
      tbl[7]  = mk(1, 0, 0, 0, 1, 0, 1);
      tbl[8]  = mk(1, 0, 0, 0, 1, 0, 1);
      tbl[9]  = mk(1, 0, 0, 0, 1, 0, 1);
      tbl[10] = mk(0, 0, 0, 0, 1, 0, 1);
      tbl[11] = mk(0, 0, 0, 0, 1, 0, 1);
      tbl[12] = mk(0, 0, 0, 1, 2, 0, 0);
      tbl[13] = mk(0, 0, 0, 0, 2, 0, 0);
      tbl[14] = mk(0, 1, 0, 0, 1, 0, 0);
      tbl[15] = mk(0, 1, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0);

      reset     = 1'b0;
      toggle_in = 1'b0;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      model_clear();
      ticks(2);
      check("reset.count", 32'(evt_count), 0);
      check("reset.ovf",   32'(ovf),       0);
      check("reset.pulse", 32'(evt_pulse), 0);
      check("reset.ack",   32'(ack_lvl),   0);
      reset = 1'b1;

      // Single toggle then the opposite edge, then drain.
      foreach (tbl[i]) begin
         toggle_in = tbl[i].tog;
         evt_ready = tbl[i].rdy;
         ovf_clr   = tbl[i].clr;
         tick();
         check($sformatf("tbl%0d.pulse", i), 32'(evt_pulse), 32'(tbl[i].e_pulse));
         check($sformatf("tbl%0d.count", i), 32'(evt_count), 32'(tbl[i].e_cnt));
         check($sformatf("tbl%0d.valid", i), 32'(evt_valid), 32'(tbl[i].e_cnt != 0));
         check($sformatf("tbl%0d.ovf", i),   32'(ovf),       32'(tbl[i].e_ovf));
         check($sformatf("tbl%0d.ack", i),   32'(ack_lvl),   32'(tbl[i].e_ack));
      end

      // Saturation with no consumer.
      for (int i = 0; i < 4; i++) begin
         toggle_in = ~toggle_in;
         ticks(6);
         check("sat.count", 32'(evt_count), (i < 3) ? 32'(i + 1) : 32'(3));
         check("sat.ovf",   32'(ovf),       32'(i == 3));
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("clr.ovf",   32'(ovf),       0);
      check("clr.count", 32'(evt_count), 3);

      // Pop on the same edge a pulse arrives, at max and below max.
      toggle_in = ~toggle_in;
      ticks(2);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("simul_max.pulse", 32'(evt_pulse), 1);
      check("simul_max.count", 32'(evt_count), 3);
      check("simul_max.ovf",   32'(ovf),       0);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("pop.count", 32'(evt_count), 2);
      toggle_in = ~toggle_in;
      ticks(2);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("simul.pulse", 32'(evt_pulse), 1);
      check("simul.count", 32'(evt_count), 2);
      ticks(3);

      // Reset mid-operation with count at max and ovf set.
      toggle_in = ~toggle_in;
      ticks(6);
      toggle_in = ~toggle_in;
      ticks(6);
      check("rst.pre_count", 32'(evt_count), 3);
      check("rst.pre_ovf",   32'(ovf),       1);
      assert_reset();
      check("rst.count", 32'(evt_count), 0);
      check("rst.valid", 32'(evt_valid), 0);
      check("rst.ovf",   32'(ovf),       0);
      check("rst.ack",   32'(ack_lvl),   0);
      @(negedge clk2);
      ticks(2);
      reset = 1'b1;
      ticks(5);
      toggle_in = ~toggle_in;
      ticks(4);
      check("post_rst.count", 32'(evt_count), 1);

      // Level held high through reset must not create an event.
      toggle_in = 1'b1;
      assert_reset();
      @(negedge clk2);
      ticks(2);
      reset = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("warm.pulse", 32'(evt_pulse), 0);
         if (k == S)     check("warm.ack_early", 32'(ack_lvl), 0);
         if (k == S + 1) check("warm.ack",       32'(ack_lvl), 1);
      end
      check("warm.count", 32'(evt_count), 0);

      // Randomized traffic against the model.
      for (int it = 0; it < 3000; it++) begin
         if ($urandom_range(0, 99) < 2) begin
            assert_reset();
            @(negedge clk2);
            ticks(int'($urandom_range(1, 2)));
            reset = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) toggle_in = ~toggle_in;
         evt_ready = ($urandom_range(0, 2) == 0);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
